// File: rtl/ripple_counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer and the display drivers.
package ripple_counter_ctrl_pkg;

  localparam int DEFAULT_WIDTH      = 3;
  localparam int DEFAULT_PRESCALE_W = 4;

  // Sequencer state encoding, also decoded by the LED/display logic.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // The counter counts as "busy" while a sequence is active or paused.
  function automatic logic is_busy(state_e s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/ripple_counter_ctrl_if.sv
// Command/status bundle between demo logic (master) and the counter sequencer (slave).
interface ripple_counter_ctrl_if #(
  parameter int WIDTH      = ripple_counter_ctrl_pkg::DEFAULT_WIDTH,
  parameter int PRESCALE_W = ripple_counter_ctrl_pkg::DEFAULT_PRESCALE_W
) ();

  // commands and configuration
  logic                  start;
  logic                  stop;
  logic                  pause;
  logic                  dir_down;
  logic                  mode_reload;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      term_val;
  logic [PRESCALE_W-1:0] prescale;

  // status
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  paused;
  logic                  tick;
  logic                  done;
  logic                  cfg_err;

  modport master (
    output start, stop, pause, dir_down, mode_reload, load_val, term_val, prescale,
    input  count, busy, paused, tick, done, cfg_err
  );

  modport slave (
    input  start, stop, pause, dir_down, mode_reload, load_val, term_val, prescale,
    output count, busy, paused, tick, done, cfg_err
  );

endinterface

// File: rtl/ripple_counter_core.sv
// WIDTH-bit count register with synchronous load, step enable and direction.
// Arithmetic wraps modulo 2^WIDTH; no saturation.
module ripple_counter_core #(
  parameter int WIDTH = ripple_counter_ctrl_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir_down,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] step_val
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Value the register would take on a step; the controller compares it
  // against the terminal so done can register on the same edge.
  assign step_val = dir_down ? (count_q - ONE) : (count_q + ONE);

  // Load has priority over a step.
  always_comb begin
    count_d = count_q;
    if (load)    count_d = load_val;
    else if (en) count_d = step_val;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ripple_counter_ctrl.sv
// Counter sequencer: captures a configuration on start, steps the core at a
// prescaled rate, and stops (one-shot) or reloads at the terminal value.
// All status outputs come straight from flops.
module ripple_counter_ctrl
  import ripple_counter_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  ripple_counter_ctrl_if.slave bus
);

  state_e                state_q,     state_d;
  logic [PRESCALE_W-1:0] pre_cnt_q,   pre_cnt_d;
  logic [PRESCALE_W-1:0] pre_sh_q,    pre_sh_d;
  logic [WIDTH-1:0]      load_sh_q,   load_sh_d;
  logic [WIDTH-1:0]      term_sh_q,   term_sh_d;
  logic                  dir_q,       dir_d;
  logic                  reload_q,    reload_d;
  // set after a terminal step in reload mode: the next step reloads
  logic                  rld_pend_q,  rld_pend_d;
  logic                  tick_q,      tick_d;
  logic                  done_q,      done_d;
  logic                  cfg_err_q,   cfg_err_d;
  logic                  busy_q,      busy_d;
  logic                  paused_q,    paused_d;

  logic                  core_load;
  logic                  core_en;
  logic [WIDTH-1:0]      core_ld_val;
  logic [WIDTH-1:0]      core_count;
  logic [WIDTH-1:0]      core_step;

  ripple_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (core_ld_val),
    .en       (core_en),
    .dir_down (dir_q),
    .count    (core_count),
    .step_val (core_step)
  );

  // Next-state, shadow capture, prescaler and pulse generation.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    pre_sh_d    = pre_sh_q;
    load_sh_d   = load_sh_q;
    term_sh_d   = term_sh_q;
    dir_d       = dir_q;
    reload_d    = reload_q;
    rld_pend_d  = rld_pend_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    core_load   = 1'b0;
    core_en     = 1'b0;
    core_ld_val = load_sh_q;

    case (state_q)
      // DONE only differs from IDLE in that count sits at the terminal.
      // stop is meaningless here, so a coincident start simply proceeds.
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          if (bus.load_val == bus.term_val) begin
            // would never terminate cleanly; reject without touching state
            cfg_err_d = 1'b1;
          end else begin
            pre_sh_d    = bus.prescale;
            load_sh_d   = bus.load_val;
            term_sh_d   = bus.term_val;
            dir_d       = bus.dir_down;
            reload_d    = bus.mode_reload;
            rld_pend_d  = 1'b0;
            pre_cnt_d   = '0;
            core_load   = 1'b1;
            core_ld_val = bus.load_val;
            state_d     = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.pause) begin
          state_d = ST_HOLD;
        end else if (pre_cnt_q == pre_sh_q) begin
          pre_cnt_d = '0;
          tick_d    = 1'b1;
          if (rld_pend_q) begin
            core_load  = 1'b1;
            rld_pend_d = 1'b0;
          end else begin
            core_en = 1'b1;
            if (core_step == term_sh_q) begin
              done_d = 1'b1;
              if (reload_q) rld_pend_d = 1'b1;
              else          state_d    = ST_DONE;
            end
          end
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end

      // count and prescaler frozen; resume exactly where we left off
      ST_HOLD: begin
        if (bus.stop)        state_d = ST_IDLE;
        else if (!bus.pause) state_d = ST_RUN;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d   = is_busy(state_d);
    paused_d = (state_d == ST_HOLD);
  end

  // State, shadow configuration and registered status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      pre_sh_q   <= '0;
      load_sh_q  <= '0;
      term_sh_q  <= '0;
      dir_q      <= 1'b0;
      reload_q   <= 1'b0;
      rld_pend_q <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      pre_sh_q   <= pre_sh_d;
      load_sh_q  <= load_sh_d;
      term_sh_q  <= term_sh_d;
      dir_q      <= dir_d;
      reload_q   <= reload_d;
      rld_pend_q <= rld_pend_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      busy_q     <= busy_d;
      paused_q   <= paused_d;
    end
  end

  assign bus.count   = core_count;
  assign bus.busy    = busy_q;
  assign bus.paused  = paused_q;
  assign bus.tick    = tick_q;
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ripple_counter_ctrl.sv
// Bench for ripple_counter_ctrl: a behavioural model predicts each cycle's
// outputs into a queue as stimulus is applied; entries are popped and
// compared one time unit after the next rising edge.
module tb_ripple_counter_ctrl;
  import ripple_counter_ctrl_pkg::*;

  localparam int W  = 3;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ripple_counter_ctrl_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  ripple_counter_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         paused;
    logic         tick;
    logic         done;
    logic         cfg_err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state
  state_e        m_state = ST_IDLE;
  logic [W-1:0]  m_cnt   = '0;
  logic [PW-1:0] m_pre   = '0;
  logic [PW-1:0] m_presc = '0;
  logic [W-1:0]  m_load  = '0;
  logic [W-1:0]  m_term  = '0;
  logic          m_dir   = 1'b0;
  logic          m_rld   = 1'b0;
  logic          m_pend  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Predict the outputs that the coming rising edge will register.
  task automatic model_step();
    exp_t         e;
    logic [W-1:0] nxt;
    e = '0;
    if (!rst) begin
      m_state = ST_IDLE; m_cnt = '0; m_pre = '0; m_presc = '0;
      m_load = '0; m_term = '0; m_dir = 1'b0; m_rld = 1'b0; m_pend = 1'b0;
    end else begin
      case (m_state)
        ST_IDLE, ST_DONE: if (bus.start) begin
          if (bus.load_val == bus.term_val) e.cfg_err = 1'b1;
          else begin
            m_load = bus.load_val; m_term = bus.term_val; m_presc = bus.prescale;
            m_dir = bus.dir_down; m_rld = bus.mode_reload; m_pend = 1'b0;
            m_cnt = bus.load_val; m_pre = '0; m_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.stop) m_state = ST_IDLE;
          else if (bus.pause) m_state = ST_HOLD;
          else if (m_pre != m_presc) m_pre = m_pre + 1'b1;
          else begin
            m_pre  = '0;
            e.tick = 1'b1;
            if (m_pend) begin
              m_cnt = m_load; m_pend = 1'b0;
            end else begin
              nxt   = m_dir ? m_cnt - 3'd1 : m_cnt + 3'd1;
              m_cnt = nxt;
              if (nxt == m_term) begin
                e.done = 1'b1;
                if (m_rld) m_pend = 1'b1;
                else       m_state = ST_DONE;
              end
            end
          end
        end
        ST_HOLD: begin
          if (bus.stop) m_state = ST_IDLE;
          else if (!bus.pause) m_state = ST_RUN;
        end
        default: m_state = ST_IDLE;
      endcase
    end
    e.count  = m_cnt;
    e.busy   = (m_state == ST_RUN) || (m_state == ST_HOLD);
    e.paused = (m_state == ST_HOLD);
    exp_q.push_back(e);
  endtask

  // One clock: predict, advance, compare.
  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("count",   32'(bus.count),   32'(e.count));
      chk("busy",    32'(bus.busy),    32'(e.busy));
      chk("paused",  32'(bus.paused),  32'(e.paused));
      chk("tick",    32'(bus.tick),    32'(e.tick));
      chk("done",    32'(bus.done),    32'(e.done));
      chk("cfg_err", 32'(bus.cfg_err), 32'(e.cfg_err));
    end
  endtask

  task automatic cfg(input logic [W-1:0] ld, input logic [W-1:0] tm, input logic dn,
                     input logic rl, input logic [PW-1:0] ps);
    bus.load_val = ld; bus.term_val = tm; bus.dir_down = dn;
    bus.mode_reload = rl; bus.prescale = ps;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  logic [W-1:0] seq_dn [7];

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    cfg(3'd0, 3'd0, 1'b0, 1'b0, 4'd0);
    #12;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    rst = 1'b1;
    cyc(); cyc();

    // one-shot up, load 0 -> term 5, step every cycle
    cfg(3'd0, 3'd5, 1'b0, 1'b0, 4'd0);
    pulse_start();
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("up_seq", 32'(bus.count), 32'(i));
      chk("up_done", 32'(bus.done), (i == 5) ? 32'd1 : 32'd0);
    end
    cyc();
    chk("up_held", 32'(bus.count), 32'd5);
    chk("up_idle", 32'(bus.busy), 32'd0);

    // reload down with wrap: 1 -> 0,7,6(done),1,0,7,6(done)
    cfg(3'd1, 3'd6, 1'b1, 1'b1, 4'd0);
    pulse_start();
    seq_dn = '{3'd0, 3'd7, 3'd6, 3'd1, 3'd0, 3'd7, 3'd6};
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("dn_seq", 32'(bus.count), 32'(seq_dn[i]));
      chk("dn_done", 32'(bus.done), (i == 2 || i == 6) ? 32'd1 : 32'd0);
      chk("dn_tick", 32'(bus.tick), 32'd1);
    end
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    chk("stop_held", 32'(bus.count), 32'd6);

    // prescale 3 with a 10-cycle pause mid-interval, plus a start while busy
    cfg(3'd2, 3'd4, 1'b0, 1'b0, 4'd3);
    pulse_start();
    cyc(); cyc();
    cfg(3'd3, 3'd3, 1'b1, 1'b1, 4'd0);
    pulse_start();
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_cnt", 32'(bus.count), 32'd2);
    end
    chk("hold_flag", 32'(bus.paused), 32'd1);
    bus.pause = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    chk("ps_end", 32'(bus.count), 32'd4);

    // rejected configuration from DONE
    cfg(3'd3, 3'd3, 1'b0, 1'b0, 4'd0);
    pulse_start();
    chk("cfg_err", 32'(bus.cfg_err), 32'd1);
    chk("cfg_cnt", 32'(bus.count), 32'd4);
    cyc();

    // start and stop together out of DONE: start wins; then stop mid-run
    cfg(3'd0, 3'd7, 1'b0, 1'b0, 4'd1);
    bus.stop = 1'b1; pulse_start(); bus.stop = 1'b0;
    chk("ss_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 5; i++) cyc();
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    cyc();

    // reset mid-run
    cfg(3'd5, 3'd2, 1'b0, 1'b1, 4'd0);
    pulse_start();
    cyc(); cyc();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy),  32'd0);
    chk("mid_rst_done",  32'(bus.done),  32'd0);
    cyc();
    rst = 1'b1;
    cyc(); cyc();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 5) == 0);
      bus.stop  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) bus.pause = ~bus.pause;
      cfg(W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), PW'($urandom_range(0, 2)));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
